fir_mac_serial: RTL and testbench

//  Parametrised time-multiplexed FIR filter: one multiplier and one accumulator are shared across TAPS taps.

---
 rtl/fir_mac_serial_if.sv | 32 +++
 rtl/fir_mac_serial.sv | 137 +++++++++++++
 tb/tb_fir_mac_serial.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_if.sv
// Streaming and coefficient-load signal bundle for fir_mac_serial.
// slave is the filter's view; master is the driver's view.
interface fir_mac_serial_if #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 14,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 16
);
  localparam int unsigned AddrW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we;
  logic [AddrW-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     clear_sat;
  logic                     sat_flag;

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear_sat,
    output in_ready, out_valid, out_data, sat_flag
  );

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear_sat,
    input  in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one multiplier and one accumulator walk all taps per sample.
// Round-half-up scaling by 2^-FRAC, output saturation with a sticky flag.
module fir_mac_serial #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 14,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 16,
  parameter int unsigned FRAC   = 14
) (
  input logic              clk,
  input logic              reset,
  fir_mac_serial_if.slave  bus
);
  localparam int unsigned AddrW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW    = IN_W + COEF_W;
  localparam int unsigned AW    = PW + $clog2(TAPS);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned RW    = AW + 1;

  localparam logic signed [RW-1:0]     RndHalf  = RW'(longint'(1) << (FRAC - 1));
  localparam logic signed [RW-1:0]     OutMax   = RW'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]     OutMin   = RW'(-(longint'(1) << (OUT_W - 1)));
  localparam logic signed [COEF_W-1:0] CoefUnit = COEF_W'(longint'(1) << FRAC);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state_q, state_d;
  logic [AddrW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [IN_W-1:0]   x_q [TAPS];
  logic signed [IN_W-1:0]   x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     sat_q, sat_d;

  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     sum;
  logic signed [RW-1:0]     rnd;
  logic signed [RW-1:0]     shifted;
  logic signed [OUT_W-1:0]  clamped;
  logic                     clamp;

  // Shared MAC datapath plus round/saturate of the running sum.
  always_comb begin
    prod    = PW'(x_q[idx_q]) * PW'(c_q[idx_q]);
    sum     = acc_q + AW'(prod);
    rnd     = RW'(sum) + RndHalf;
    shifted = rnd >>> FRAC;
    clamp   = 1'b0;
    clamped = shifted[OUT_W-1:0];
    if (shifted > OutMax) begin
      clamped = OutMax[OUT_W-1:0];
      clamp   = 1'b1;
    end else if (shifted < OutMin) begin
      clamped = OutMin[OUT_W-1:0];
      clamp   = 1'b1;
    end
  end

  // Next-state logic: sample capture, tap sequencing, output handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    x_d     = x_q;
    c_d     = c_q;
    out_d   = out_q;
    sat_d   = sat_q;
    if (bus.clear_sat) begin
      sat_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        // Written before the sample is captured, so a same-cycle write applies to it.
        if (bus.coef_we && (32'(bus.coef_addr) < TAPS)) begin
          c_d[bus.coef_addr] = bus.coef_data;
        end
        if (bus.in_valid) begin
          x_d[0] = bus.in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = sum;
        idx_d = idx_q + AddrW'(1);
        if (32'(idx_q) == TAPS - 1) begin
          out_d   = clamped;
          state_d = StOut;
          // Set overrides a same-cycle clear.
          if (clamp) begin
            sat_d = 1'b1;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset to pass-through coefficients.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= (k == 0) ? CoefUnit : '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_data  = out_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_fir_mac_serial.sv
// Randomized self-checking bench for fir_mac_serial against a direct-form FIR model.
module tb_fir_mac_serial;
  localparam int IN_W   = 12;
  localparam int OUT_W  = 14;
  localparam int COEF_W = 16;
  localparam int TAPS   = 16;
  localparam int FRAC   = 14;
  localparam longint OMax = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OMin = -(longint'(1) << (OUT_W - 1));

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference model: delay-line history, coefficient table, sticky flag.
  longint hist [TAPS];
  longint coef [TAPS];
  bit     msat;

  fir_mac_serial_if #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus ();

  fir_mac_serial #(
    .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC(FRAC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      coef[k] = 0;
    end
    coef[0] = longint'(1) << FRAC;
    msat = 1'b0;
  endfunction

  function automatic longint model_push(input longint v);
    longint s;
    longint r;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += hist[k] * coef[k];
    r = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > OMax) begin
      r = OMax;
      msat = 1'b1;
    end else if (r < OMin) begin
      r = OMin;
      msat = 1'b1;
    end
    return r;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic write_coef(input int addr, input longint data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = COEF_W'(data);
    @(posedge clk);
    if (addr < TAPS) coef[addr] = data;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_clear();
    bus.clear_sat = 1'b1;
    @(posedge clk);
    msat = 1'b0;
    @(negedge clk);
    bus.clear_sat = 1'b0;
    check("clear_sat", bus.sat_flag, msat);
  endtask

  // Send one sample and follow it to its output transfer.
  task automatic send(input longint v, input int hold, input bit mac_wr, input int sw_addr,
                      input longint sw_data, input bit clr_end, output longint got);
    longint exp;
    int     n;
    check("idle_in_ready", bus.in_ready, 1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = IN_W'(v);
    if (sw_addr >= 0) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(sw_addr);
      bus.coef_data = COEF_W'(sw_data);
    end
    @(posedge clk);
    if (sw_addr >= 0 && sw_addr < TAPS) coef[sw_addr] = sw_data;
    if (clr_end) msat = 1'b0;
    exp = model_push(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we  = mac_wr;
    if (mac_wr) begin
      bus.coef_addr = '0;
      bus.coef_data = '0;
    end
    check("busy_in_ready", bus.in_ready, 0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < TAPS + 8) begin
      bus.clear_sat = clr_end && (n == TAPS - 1);
      @(posedge clk);
      @(negedge clk);
      n++;
      bus.coef_we   = 1'b0;
      bus.clear_sat = 1'b0;
    end
    got = longint'(bus.out_data);
    check("latency", n, TAPS);
    check("out_data", bus.out_data, exp);
    check("sat_flag", bus.sat_flag, msat);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, exp);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    longint got;
    int     seen;
    logic signed [IN_W-1:0]   rv;
    logic signed [COEF_W-1:0] rc;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.clear_sat = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_sat", bus.sat_flag, 0);

    // Pass-through with reset coefficients.
    send(291, 0, 0, -1, 0, 0, got);
    check("t1_const", got, 291);

    // Ramp coefficients, impulse response.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * k);
    for (int k = 0; k < TAPS; k++) begin
      send((k == 0) ? 2047 : 0, 0, 0, -1, 0, 0, got);
      check("t2_const", got, (2047 * k + 8) / 16);
    end

    // Saturation both ways, set-beats-clear, then clear.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16383);
    for (int k = 0; k < TAPS; k++) send(2047, 0, 0, -1, 0, 0, got);
    check("t3_pos", got, OMax);
    check("t3_sat", bus.sat_flag, 1);
    for (int k = 0; k < TAPS; k++) send(-2048, 0, 0, -1, 0, k == TAPS - 1, got);
    check("t3_neg", got, OMin);
    check("t3_set_wins", bus.sat_flag, 1);
    pulse_clear();

    // Long output stall with inputs offered and dropped.
    send(-37, 20, 0, -1, 0, 0, got);
    send(5, 0, 0, -1, 0, 0, got);

    // Reset in the middle of MAC aborts the sample.
    bus.in_valid = 1'b1;
    bus.in_data  = IN_W'(555);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    do_reset();
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int k = 0; k < TAPS + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("t5_no_output", seen, 0);
    send(100, 0, 0, -1, 0, 0, got);
    check("t5_const", got, 100);

    // Coefficient write during MAC is ignored.
    send(300, 0, 1, -1, 0, 0, got);
    check("t6_cur", got, 300);
    send(400, 0, 0, -1, 0, 0, got);
    check("t6_next", got, 400);

    // Random coefficients, samples, stalls and same-cycle writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rc = COEF_W'($urandom);
        if ($urandom_range(0, 1) == 0) rc = COEF_W'(longint'($urandom_range(0, 4095)) - 2048);
        write_coef($urandom_range(0, TAPS - 1), longint'(rc));
      end
      if ($urandom_range(0, 7) == 0) pulse_clear();
      rv = IN_W'($urandom);
      rc = COEF_W'(longint'($urandom_range(0, 8191)) - 4096);
      send(longint'(rv), $urandom_range(0, 2), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TAPS - 1)) : -1,
           longint'(rc), 0, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
